// File: rtl/exe_pkg.sv
// Shared constants and types for the MIPS execute stage.
package exe_pkg;

  localparam int MUL_CYCLES_DEF = 32;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per step, low 32 product bits.
import exe_pkg::*;

module exe_mul_seq #(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] mplier_i,
  output logic [31:0] acc_o,
  output logic        done_o
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [31:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [31:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = {mcand_q[30:0], 1'b0};
      mplier_d = {1'b0, mplier_q[31:1]};
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  // Final step is in flight this cycle; accumulator is complete after the edge.
  assign done_o = step_i && (cnt_q == CW'(MUL_CYCLES - 1));

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, branch resolution, control gating, optional iterative MUL.
// Define EXE_MUL_EN to build the multiplier FSM; otherwise MUL yields 0 and stall is tied low.
import exe_pkg::*;

module exe_stage #(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] Val1,
  input  logic [31:0] Val2,
  input  logic [31:0] Reg2,
  input  logic [31:0] PC_in,
  input  logic [1:0]  Br_type,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  input  logic [4:0]  Dest_in,
  output logic [31:0] ALU_result,
  output logic [31:0] Br_addr,
  output logic        Br_taken,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        WB_EN,
  output logic [4:0]  Dest,
  output logic [31:0] ST_val,
  output logic        stall
);

  logic [4:0]  shamt;
  logic        br_cond;
  logic [31:0] mul_acc;

  assign shamt = Val2[4:0];

`ifdef EXE_MUL_EN
  mul_state_e state_q, state_d;
  logic       mul_start, mul_step, mul_done, busy;

  exe_mul_seq #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .step_i   (mul_step),
    .mcand_i  (Val1),
    .mplier_i (Val2),
    .acc_o    (mul_acc),
    .done_o   (mul_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: if (EXE_CMD == CMD_MUL) begin
        busy      = 1'b1;
        mul_start = 1'b1;
        state_d   = BUSY;
      end
      BUSY: begin
        busy     = 1'b1;
        mul_step = 1'b1;
        if (mul_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so a MUL still sitting in ID/EXE cannot hold stall during reset.
  assign stall = busy & rst;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst};
  assign mul_acc   = '0;
  assign stall     = 1'b0;
`endif

  always_comb begin
    ALU_result = '0;
    case (EXE_CMD)
      CMD_ADD: ALU_result = Val1 + Val2;
      CMD_SUB: ALU_result = Val1 - Val2;
      CMD_AND: ALU_result = Val1 & Val2;
      CMD_OR:  ALU_result = Val1 | Val2;
      CMD_NOR: ALU_result = ~(Val1 | Val2);
      CMD_XOR: ALU_result = Val1 ^ Val2;
      CMD_SLL: ALU_result = Val1 << shamt;
      CMD_SRA: ALU_result = $unsigned($signed(Val1) >>> shamt);
      CMD_SRL: ALU_result = Val1 >> shamt;
`ifdef EXE_MUL_EN
      CMD_MUL: ALU_result = mul_acc;
`endif
      default: ALU_result = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (Br_type)
      BR_BEZ:  br_cond = (Val1 == 32'd0);
      BR_BNE:  br_cond = (Val1 != Reg2);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign Br_taken = br_cond & ~stall;
  assign Br_addr  = PC_in + {Val2[29:0], 2'b00};

  assign MEM_R_EN = MEM_R_EN_in & ~stall;
  assign MEM_W_EN = MEM_W_EN_in & ~stall;
  assign WB_EN    = WB_EN_in & ~stall;
  assign Dest     = Dest_in;
  assign ST_val   = Reg2;

  logic unused_acc;
  assign unused_acc = &{1'b0, mul_acc};

endmodule
